// File: rtl/key_event_decoder_if.sv
// Pushbutton side of the key event decoder: raw active-low keys in,
// debounced levels and one-cycle event pulses out.
interface key_event_decoder_if;
    logic [3:0] key_n;
    logic [3:0] key_level;
    logic [3:0] press_pulse;
    logic [3:0] short_pulse;
    logic [3:0] long_pulse;
    logic [3:0] repeat_pulse;

    modport master (
        output key_n,
        input  key_level, press_pulse, short_pulse, long_pulse, repeat_pulse
    );

    modport slave (
        input  key_n,
        output key_level, press_pulse, short_pulse, long_pulse, repeat_pulse
    );
endinterface

// File: rtl/key_event_decoder.sv
// Four independent pushbutton channels: synchronize, debounce, then classify
// each press into press / short / long / auto-repeat pulses.
module key_event_channel #(
    parameter int unsigned DEBOUNCE_CYC     = 1_000_000,
    parameter int unsigned LONG_CYC         = 100_000_000,
    parameter int unsigned REPEAT_DELAY_CYC = 25_000_000,
    parameter int unsigned REPEAT_CYC       = 5_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic key_level,
    output logic press_pulse,
    output logic short_pulse,
    output logic long_pulse,
    output logic repeat_pulse
);
    typedef enum logic [1:0] {IDLE, HELD, LONG} state_t;

    state_t      state;
    logic        sync1, s;
    logic [31:0] deb_cnt, hold_cnt, rep_cnt;
    logic        rep_armed;
    logic        accept, rep_hit;

    // Level change is committed on the same edge the FSM reacts, so pulses
    // line up with the first cycle of the new key_level.
    assign accept  = (s != key_level) && (deb_cnt == DEBOUNCE_CYC - 1);
    assign rep_hit = rep_cnt == ((rep_armed ? REPEAT_CYC : REPEAT_DELAY_CYC) - 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1        <= 1'b0;
            s            <= 1'b0;
            deb_cnt      <= '0;
            key_level    <= 1'b0;
            state        <= IDLE;
            hold_cnt     <= '0;
            rep_cnt      <= '0;
            rep_armed    <= 1'b0;
            press_pulse  <= 1'b0;
            short_pulse  <= 1'b0;
            long_pulse   <= 1'b0;
            repeat_pulse <= 1'b0;
        end else begin
            sync1 <= ~key_n;
            s     <= sync1;

            if (s == key_level) begin
                deb_cnt <= '0;
            end else if (accept) begin
                deb_cnt   <= '0;
                key_level <= s;
            end else begin
                deb_cnt <= deb_cnt + 32'd1;
            end

            press_pulse  <= 1'b0;
            short_pulse  <= 1'b0;
            long_pulse   <= 1'b0;
            repeat_pulse <= 1'b0;

            case (state)
                IDLE: begin
                    if (accept && s) begin
                        state       <= HELD;
                        press_pulse <= 1'b1;
                        hold_cnt    <= '0;
                        rep_cnt     <= '0;
                        rep_armed   <= 1'b0;
                    end
                end
                HELD, LONG: begin
                    // An accepted release pre-empts any long/repeat due this edge.
                    if (accept) begin
                        short_pulse <= (state == HELD);
                        state       <= IDLE;
                    end else begin
                        if (state == HELD) begin
                            if (hold_cnt == LONG_CYC - 1) begin
                                long_pulse <= 1'b1;
                                state      <= LONG;
                            end else begin
                                hold_cnt <= hold_cnt + 32'd1;
                            end
                        end
                        if (rep_hit) begin
                            repeat_pulse <= 1'b1;
                            rep_cnt      <= '0;
                            rep_armed    <= 1'b1;
                        end else begin
                            rep_cnt <= rep_cnt + 32'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

module key_event_decoder #(
    parameter int unsigned DEBOUNCE_CYC     = 1_000_000,
    parameter int unsigned LONG_CYC         = 100_000_000,
    parameter int unsigned REPEAT_DELAY_CYC = 25_000_000,
    parameter int unsigned REPEAT_CYC       = 5_000_000
) (
    input logic                clk,
    input logic                reset,
    key_event_decoder_if.slave bus
);
    localparam int NUM_KEYS = 4;

    logic [NUM_KEYS-1:0] level, press, short_p, long_p, rep;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_event_channel #(
            .DEBOUNCE_CYC    (DEBOUNCE_CYC),
            .LONG_CYC        (LONG_CYC),
            .REPEAT_DELAY_CYC(REPEAT_DELAY_CYC),
            .REPEAT_CYC      (REPEAT_CYC)
        ) u_ch (
            .clk         (clk),
            .reset       (reset),
            .key_n       (bus.key_n[k]),
            .key_level   (level[k]),
            .press_pulse (press[k]),
            .short_pulse (short_p[k]),
            .long_pulse  (long_p[k]),
            .repeat_pulse(rep[k])
        );
    end

    assign bus.key_level    = level;
    assign bus.press_pulse  = press;
    assign bus.short_pulse  = short_p;
    assign bus.long_pulse   = long_p;
    assign bus.repeat_pulse = rep;
endmodule

// File: tb/tb_key_event_decoder.sv
// Scoreboard bench for key_event_decoder with short parameters.
module tb_key_event_decoder;
    localparam int DEB = 4, LNG = 40, RD = 20, RP = 5;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   tests = 0, fails = 0;

    key_event_decoder_if bus();

    key_event_decoder #(
        .DEBOUNCE_CYC(DEB), .LONG_CYC(LNG), .REPEAT_DELAY_CYC(RD), .REPEAT_CYC(RP)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int at; int kind; int key; } ev_t;
    ev_t   exp_q[$];
    string kname[4] = '{"press", "short", "long", "repeat"};

    typedef struct { logic [3:0] mask; int hold; } vec_t;
    vec_t vt[8];

    task automatic push_ev(int at, int kind, int key);
        ev_t e;
        e.at = at; e.kind = kind; e.key = key;
        exp_q.push_back(e);
    endtask

    // Events of one press whose level is 1 in cycles [p, f).
    task automatic expect_press(int k, int p, int f, bit rel);
        push_ev(p, 0, k);
        if (p + LNG < f) push_ev(p + LNG, 2, k);
        else if (rel)    push_ev(f, 1, k);
        for (int r = p + RD; r < f; r += RP) push_ev(r, 3, k);
    endtask

    task automatic chk(string name, logic [3:0] act, logic [3:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drain(string name);
        #1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL %s: %0d expected pulses never seen, first %s key%0d at cycle %0d",
                     name, exp_q.size(), kname[exp_q[0].kind], exp_q[0].key, exp_q[0].at);
            exp_q.delete();
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        logic [3:0] p [4];
        int idx;
        p[0] = bus.press_pulse;
        p[1] = bus.short_pulse;
        p[2] = bus.long_pulse;
        p[3] = bus.repeat_pulse;
        for (int kd = 0; kd < 4; kd++) begin
            for (int k = 0; k < 4; k++) begin
                if (p[kd][k] === 1'b1) begin
                    idx = -1;
                    for (int i = 0; i < exp_q.size(); i++)
                        if (idx < 0 && exp_q[i].at == cyc && exp_q[i].kind == kd && exp_q[i].key == k)
                            idx = i;
                    tests++;
                    if (idx < 0) begin
                        fails++;
                        $display("FAIL sb_%s key%0d: pulse seen at cycle %0d, expected none",
                                 kname[kd], k, cyc);
                    end else begin
                        exp_q.delete(idx);
                    end
                end
            end
        end
    end

    initial begin
        int c, c1, p0, p1, cr;
        vt[0] = '{4'b0010, 10};   // plain short press, other keys quiet
        vt[1] = '{4'b1000, 10};
        vt[2] = '{4'b0001, 100};  // long + repeats, no short
        vt[3] = '{4'b0100, 3};    // glitch just under the debounce window
        vt[4] = '{4'b0100, 4};    // shortest accepted press
        vt[5] = '{4'b0001, 39};   // repeats but released before long
        vt[6] = '{4'b0010, 42};   // just past long
        vt[7] = '{4'b1001, 10};   // simultaneous keys

        bus.key_n = 4'hF;
        tick(2);
        chk("rst_level", bus.key_level, 4'h0);
        chk("rst_press", bus.press_pulse, 4'h0);
        chk("rst_short", bus.short_pulse, 4'h0);
        chk("rst_long", bus.long_pulse, 4'h0);
        chk("rst_repeat", bus.repeat_pulse, 4'h0);
        reset = 1'b0;
        tick(3);

        for (int v = 0; v < 8; v++) begin
            c = cyc;
            bus.key_n = ~vt[v].mask;
            if (vt[v].hold >= DEB)
                for (int k = 0; k < 4; k++)
                    if (vt[v].mask[k])
                        expect_press(k, c + DEB + 2, c + vt[v].hold + DEB + 2, 1'b1);
            for (int i = 1; i <= vt[v].hold; i++) begin
                @(negedge clk);
                if (i == DEB + 2) chk("press_vec", bus.press_pulse, vt[v].mask);
                if (i == vt[v].hold)
                    chk("level_held", bus.key_level, (vt[v].hold >= DEB + 2) ? vt[v].mask : 4'h0);
            end
            bus.key_n = 4'hF;
            tick(DEB + 2 + RD + RP);
            chk("level_released", bus.key_level, 4'h0);
            drain("missed_table");
        end

        // Key 2 bouncing every 2 cycles never settles long enough.
        for (int i = 0; i < 30; i++) begin
            bus.key_n[2] = ((i / 2) % 2) == 1;
            @(negedge clk);
            chk("bounce_level", bus.key_level, 4'h0);
        end
        bus.key_n = 4'hF;
        tick(DEB + 4);
        drain("missed_bounce");

        // Reset while key 0 is in LONG; key stays down through reset.
        c = cyc;
        p0 = c + DEB + 2;
        bus.key_n = 4'b1110;
        expect_press(0, p0, p0 + 46, 1'b0);
        while (cyc < p0 + 45) @(negedge clk);
        chk("pre_rst_level", bus.key_level, 4'b0001);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_level", bus.key_level, 4'h0);
        chk("async_rst_pulses", bus.press_pulse | bus.short_pulse | bus.long_pulse | bus.repeat_pulse, 4'h0);
        tick(3);
        drain("missed_prereset");
        c1 = cyc;
        reset = 1'b0;
        p1 = c1 + DEB + 2;
        cr = p1 + 45;
        expect_press(0, p1, cr + DEB + 2, 1'b1);
        while (cyc < cr) @(negedge clk);
        bus.key_n = 4'hF;
        tick(DEB + 12);
        chk("post_rst_release", bus.key_level, 4'h0);
        drain("missed_postreset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
